// File: rtl/airi5c_dmem_req_buffer_pkg.sv
// Shared size encodings and byte-lane helpers for the dmem request buffer.
package airi5c_dmem_req_buffer_pkg;

    typedef enum logic [1:0] {
        DMEM_SIZE_B = 2'd0,
        DMEM_SIZE_H = 2'd1,
        DMEM_SIZE_W = 2'd2,
        DMEM_SIZE_R = 2'd3
    } dmem_size_e;

    function automatic logic [3:0] lane_wstrb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            DMEM_SIZE_B: return 4'b0001 << a;
            DMEM_SIZE_H: return 4'b0011 << {a[1], 1'b0};
            default:     return 4'b1111;
        endcase
    endfunction

    // Reserved size 3 is checked like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            DMEM_SIZE_B: return 1'b0;
            DMEM_SIZE_H: return a[0];
            default:     return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/airi5c_dmem_req_fifo.sv
// Generic DEPTH x W FIFO with flush; head is a combinational read, push-to-head latency 1 cycle.
// Push is ignored when full, pop ignored when empty; flush clears count and pointers.
module airi5c_dmem_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/airi5c_dmem_req_buffer.sv
// EX->dmem request queue: zero-latency bypass when empty, else oldest entry; ex_ready depends only on occupancy.
// Optional AIRI5C_DMEM_MISALIGN_TRAP_EN drops misaligned half/word requests and pulses misalign.
module airi5c_dmem_req_buffer
    import airi5c_dmem_req_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  ex_addr,
    input  logic [XLEN-1:0]  ex_wdata,
    input  logic             ex_wr,
    input  logic [1:0]       ex_size,
    input  logic             flush,
    output logic             dmem_valid,
    input  logic             dmem_ready,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    output logic             dmem_wr,
    output logic [CNT_W-1:0] occupancy,
    output logic             misalign
);
    localparam int REQ_W = 2 * XLEN + 3;

    logic [REQ_W-1:0] ex_req, head_req, sel_req;
    logic [XLEN-1:0]  sel_addr, sel_wdata, last_addr;
    logic [1:0]       sel_size;
    logic             sel_wr, empty, ex_acc, bypass, push;

`ifdef AIRI5C_DMEM_MISALIGN_TRAP_EN
    logic mis, misalign_q;
    assign mis    = is_misaligned(ex_size, ex_addr[1:0]);
    assign ex_acc = ex_valid && ex_ready && !mis;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) misalign_q <= 1'b0;
        else         misalign_q <= ex_valid && ex_ready && mis;
    end
    assign misalign = misalign_q;
`else
    assign ex_acc   = ex_valid && ex_ready;
    assign misalign = 1'b0;
`endif

    assign empty    = (occupancy == '0);
    assign ex_ready = (occupancy != CNT_W'(DEPTH));
    assign bypass   = empty && ex_acc;
    // A bypassed request only lands in the queue if the bus stalls it.
    assign push     = ex_acc && !(bypass && dmem_ready) && !flush;

    assign ex_req  = {ex_addr, ex_wdata, ex_size, ex_wr};
    assign sel_req = empty ? ex_req : head_req;

    assign sel_addr  = sel_req[REQ_W-1 -: XLEN];
    assign sel_wdata = sel_req[XLEN+2 -: XLEN];
    assign sel_size  = sel_req[2:1];
    assign sel_wr    = sel_req[0];

    airi5c_dmem_req_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (!empty && dmem_ready),
        .flush  (flush),
        .din    (ex_req),
        .head   (head_req),
        .count  (occupancy)
    );

    assign dmem_valid = !empty || bypass;
    assign dmem_addr  = dmem_valid ? sel_addr : last_addr;
    assign dmem_wr    = dmem_valid && sel_wr;
    assign dmem_wstrb = dmem_wr ? lane_wstrb(sel_size, sel_addr[1:0]) : 4'b0000;

    always_comb begin
        case (sel_size)
            DMEM_SIZE_B: dmem_wdata = {(XLEN/8){sel_wdata[7:0]}};
            DMEM_SIZE_H: dmem_wdata = {(XLEN/16){sel_wdata[15:0]}};
            default:     dmem_wdata = sel_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)         last_addr <= '0;
        else if (dmem_valid) last_addr <= sel_addr;
    end

endmodule

// File: tb/tb_airi5c_dmem_req_buffer.sv
// Scoreboard bench: stimulus queues expected bus transfers, a negedge monitor checks every handshake.
module tb_airi5c_dmem_req_buffer;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        ex_valid = 1'b0, ex_wr = 1'b0, flush = 1'b0, dmem_ready = 1'b0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [1:0]  ex_size = 2'd2;
    logic        ex_ready, dmem_valid, dmem_wr, misalign;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [1:0]  occupancy;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    airi5c_dmem_req_buffer #(.XLEN(32), .DEPTH(2)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_wr      (ex_wr),
        .ex_size    (ex_size),
        .flush      (flush),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wr    (dmem_wr),
        .occupancy  (occupancy),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        exp_t e;
        e.addr = a; e.wdata = d; e.wstrb = s; e.wr = w;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus just after the edge, then settle before checks.
    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [1:0] s, input logic r, input logic f);
        @(posedge clk); #1;
        ex_valid = v; ex_addr = a; ex_wdata = d; ex_wr = w; ex_size = s;
        dmem_ready = r; flush = f;
        #2;
    endtask

    task automatic idle(input logic r);
        drv(1'b0, 32'h0, 32'h0, 1'b0, 2'd2, r, 1'b0);
    endtask

    // Monitor: every bus handshake must match the oldest expected transfer.
    always @(negedge clk) begin
        if (nreset && dmem_valid && dmem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got addr 0x%0h required no transfer", dmem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_addr", dmem_addr, e.addr);
                chk("xfer_wdata", dmem_wdata, e.wdata);
                chk("xfer_wstrb", {28'h0, dmem_wstrb}, {28'h0, e.wstrb});
                chk("xfer_wr", {31'h0, dmem_wr}, {31'h0, e.wr});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", {31'h0, dmem_valid}, 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
        chk("rst_wr", {31'h0, dmem_wr}, 32'd0);
        chk("rst_misalign", {31'h0, misalign}, 32'd0);
        chk("rst_ex_ready", {31'h0, ex_ready}, 32'd1);
        @(posedge clk); #1 nreset = 1'b1;

        // 1: bypass word load with bus ready
        expect_xfer(32'h100, 32'h0, 4'h0, 1'b0);
        drv(1, 32'h100, 32'h0, 0, 2'd2, 1, 0);
        chk("t1_valid", {31'h0, dmem_valid}, 32'd1);
        chk("t1_addr", dmem_addr, 32'h100);
        chk("t1_wstrb", {28'h0, dmem_wstrb}, 32'h0);
        idle(1'b1);
        chk("t1_occ", 32'(occupancy), 32'd0);
        chk("t1_idle_valid", {31'h0, dmem_valid}, 32'd0);
        chk("t1_hold_addr", dmem_addr, 32'h100);

        // 2: fill to DEPTH with bus stalled, third request blocked
        expect_xfer(32'h10, 32'h11111111, 4'hF, 1'b1);
        drv(1, 32'h10, 32'h11111111, 1, 2'd2, 0, 0);
        chk("t2_bypass_addr", dmem_addr, 32'h10);
        expect_xfer(32'h14, 32'h22222222, 4'hF, 1'b1);
        drv(1, 32'h14, 32'h22222222, 1, 2'd2, 0, 0);
        chk("t2_occ1", 32'(occupancy), 32'd1);
        chk("t2_head_addr", dmem_addr, 32'h10);
        drv(1, 32'h18, 32'h33333333, 1, 2'd2, 0, 0);
        chk("t2_occ2", 32'(occupancy), 32'd2);
        chk("t2_full_ready", {31'h0, ex_ready}, 32'd0);
        drv(1, 32'h18, 32'h33333333, 1, 2'd2, 0, 0);
        chk("t2_head_stable", dmem_addr, 32'h10);
        drv(1, 32'h18, 32'h33333333, 1, 2'd2, 1, 0);
        chk("t2_still_full", {31'h0, ex_ready}, 32'd0);
        expect_xfer(32'h18, 32'h33333333, 4'hF, 1'b1);
        drv(1, 32'h18, 32'h33333333, 1, 2'd2, 1, 0);
        chk("t2_occ_after_pop", 32'(occupancy), 32'd1);
        chk("t2_ready_again", {31'h0, ex_ready}, 32'd1);
        chk("t2_second_head", dmem_addr, 32'h14);
        idle(1'b1);
        chk("t2_occ_pushpop", 32'(occupancy), 32'd1);
        chk("t2_third_head", dmem_addr, 32'h18);
        idle(1'b1);
        chk("t2_drained", 32'(occupancy), 32'd0);
        chk("t2_hold_addr", dmem_addr, 32'h18);

        // 3: lane formatting
        expect_xfer(32'h203, 32'hABABABAB, 4'b1000, 1'b1);
        drv(1, 32'h203, 32'h000000AB, 1, 2'd0, 1, 0);
        chk("t3_sb_wstrb", {28'h0, dmem_wstrb}, 32'h8);
        chk("t3_sb_wdata", dmem_wdata, 32'hABABABAB);
        expect_xfer(32'h202, 32'h12341234, 4'b1100, 1'b1);
        drv(1, 32'h202, 32'h00001234, 1, 2'd1, 1, 0);
        chk("t3_sh_wstrb", {28'h0, dmem_wstrb}, 32'hC);
        chk("t3_sh_wdata", dmem_wdata, 32'h12341234);
        expect_xfer(32'h201, 32'hC5C5C5C5, 4'b0000, 1'b0);
        drv(1, 32'h201, 32'hFFFFFFC5, 0, 2'd0, 1, 0);
        chk("t3_lb_wstrb", {28'h0, dmem_wstrb}, 32'h0);

        // 4: steady push+pop with one queued entry; pointers wrap every other cycle
        expect_xfer(32'h400, 32'h0, 4'hF, 1'b1);
        drv(1, 32'h400, 32'h0, 1, 2'd2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            expect_xfer(32'h404 + 32'(4 * i), 32'(i + 1), 4'hF, 1'b1);
            drv(1, 32'h404 + 32'(4 * i), 32'(i + 1), 1, 2'd2, 1, 0);
            chk("t4_occ_steady", 32'(occupancy), 32'd1);
        end
        idle(1'b1);
        idle(1'b1);
        chk("t4_drained", 32'(occupancy), 32'd0);

        // 5: flush at full occupancy; head handshake in the flush cycle still counts
        drv(1, 32'h500, 32'h5, 1, 2'd2, 0, 0);
        drv(1, 32'h504, 32'h6, 1, 2'd2, 0, 0);
        expect_xfer(32'h500, 32'h5, 4'hF, 1'b1);
        drv(1, 32'h508, 32'h7, 1, 2'd2, 1, 1);
        chk("t5_occ_before", 32'(occupancy), 32'd2);
        idle(1'b0);
        chk("t5_occ_flushed", 32'(occupancy), 32'd0);
        chk("t5_valid", {31'h0, dmem_valid}, 32'd0);
        chk("t5_hold_addr", dmem_addr, 32'h500);

        // 5b: async reset mid-stall, nothing re-issued afterwards
        drv(1, 32'h600, 32'h8, 1, 2'd2, 0, 0);
        drv(1, 32'h604, 32'h9, 1, 2'd2, 0, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0; nreset = 1'b0;
        #2;
        chk("t5_rst_occ", 32'(occupancy), 32'd0);
        chk("t5_rst_valid", {31'h0, dmem_valid}, 32'd0);
        chk("t5_rst_addr", dmem_addr, 32'h0);
        chk("t5_rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
        @(posedge clk); #1 nreset = 1'b1;
        idle(1'b1);
        chk("t5_no_reissue", {31'h0, dmem_valid}, 32'd0);

        // 6: misaligned word load
`ifdef AIRI5C_DMEM_MISALIGN_TRAP_EN
        drv(1, 32'h102, 32'h0, 0, 2'd2, 1, 0);
        chk("t6_trap_valid", {31'h0, dmem_valid}, 32'd0);
        idle(1'b1);
        chk("t6_misalign_pulse", {31'h0, misalign}, 32'd1);
        idle(1'b1);
        chk("t6_misalign_end", {31'h0, misalign}, 32'd0);
`else
        expect_xfer(32'h102, 32'h0, 4'h0, 1'b0);
        drv(1, 32'h102, 32'h0, 0, 2'd2, 1, 0);
        chk("t6_pass_valid", {31'h0, dmem_valid}, 32'd1);
        chk("t6_pass_addr", dmem_addr, 32'h102);
        idle(1'b1);
        chk("t6_misalign_low", {31'h0, misalign}, 32'd0);
`endif
        idle(1'b1);
        idle(1'b1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
